act_c2_cfg_loader: RTL and testbench
====================================

Name: act_c2_cfg_loader

Overview:
- Serial configuration loader for a bank of ACT C2 logic cells.
- Accepts a framed, parity-protected bitstream on a valid/ready serial interface.
- Assembles the frame in a shadow register; commits it atomically to the D00..D11 data inputs of CELLS cells.
- Sits between the programming port and the cell array. The cells never see a partially loaded configuration.

Parameters:
- CELLS, 4, number of ACT C2 cells configured by one frame.
- BITS, 1, width of each cell data input (D00/D01/D10/D11).
- Derived PAYLOAD = CELLS*4*BITS, number of payload bits per frame.
- Derived CW = $clog2(PAYLOAD+1), bit counter width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin frame; sampled only in IDLE.
- abort  input  1  cancel frame in progress; no commit.
- sin  input  1  serial data bit.
- sin_valid  input  1  sin carries a bit this cycle.
- sin_ready  output  1  loader accepts a bit this cycle.
- cfg  output  PAYLOAD  committed configuration. Cell c, input j occupies cfg[(4c+j)*BITS +: BITS], where j=0:D00, 1:D01, 2:D10, 3:D11.
- cfg_valid  output  1  at least one frame committed since reset.
- busy  output  1  frame in progress (LOAD or PARITY).
- done  output  1  one-cycle pulse: frame committed.
- err  output  1  one-cycle pulse: parity failure, frame discarded.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; cfg, shadow, count, parity accumulator = 0; cfg_valid=busy=done=err=sin_ready=0.
- Transfer rule: a bit is accepted only on a rising edge with sin_valid=1 and sin_ready=1. Idle gaps (sin_valid=0) are unlimited and change nothing.
- States: IDLE, LOAD, PARITY. All outputs are registered.
- IDLE:
  - sin_ready=0, busy=0.
  - start=1 -> LOAD next cycle; count=0, parity accumulator=0, shadow=0.
  - abort in IDLE has no effect.
- LOAD:
  - sin_ready=1, busy=1.
  - Each accepted bit: shadow <= {shadow[PAYLOAD-2:0], sin} (first bit ends at the MSB); parity ^= sin; count++.
  - The accepted bit with count==PAYLOAD-1 -> PARITY.
- PARITY:
  - sin_ready=1, busy=1.
  - The accepted bit is the even-parity bit: the frame is good if the payload XOR parity bit == 0.
  - Good: cfg <= shadow, cfg_valid <= 1, done=1 for one cycle; -> IDLE.
  - Bad: cfg unchanged, err=1 for one cycle; -> IDLE.
  - Latency: cfg, done and err update on the same edge that accepts the parity bit.
- abort=1 in LOAD or PARITY:
  - -> IDLE next edge; shadow discarded; no done, no err.
  - abort beats a simultaneously accepted bit, including the parity bit.
- start while busy is ignored. start in the cycle done/err pulses (state=IDLE) begins a new frame immediately.
- cfg_valid is sticky until reset. err never clears cfg or cfg_valid.
- Reset mid-frame clears everything, including a previously committed cfg.
- done and err are never high together. busy deasserts in the cycle done or err asserts.
- sin_ready is low in the cycle after the parity bit is accepted, so back-to-back frames require a new start.

Test Plan:
- CELLS=2, BITS=1, PAYLOAD=8. start, then bits 1,0,1,0,0,1,1,0 and parity 0, all with sin_valid=1 -> cfg=8'hA6, cfg_valid=1, single done pulse, busy low after, err never high.
- Same frame with parity 1 -> err one cycle, cfg stays 8'h00 (or the previous value), cfg_valid unchanged, no done.
- Frame 8'hFF, parity 0, with sin_valid dropped for 3 cycles after bits 2 and 5 -> cfg=8'hFF. count and shadow hold during the gaps; sin_ready stays 1.
- Commit 8'hA6. Start a new frame, send 4 bits, assert abort -> returns to IDLE; cfg stays 8'hA6; no done/err. A subsequent full frame 8'h3C, parity 0 -> cfg=8'h3C.
- Pulse start during LOAD and assert abort together with the parity bit -> extra start ignored, abort wins, cfg unchanged. Then drop rst_n mid-frame -> all outputs 0 immediately, without a clock edge.
- CELLS=4, BITS=2 (PAYLOAD=32). Send 32'h0123_4567 MSB-first plus correct parity -> cfg=32'h01234567. Cell 0 D00=cfg[1:0]=2'b11, cell 3 D11=cfg[31:30]=2'b00.

Source files
------------

// File: rtl/act_c2_cfg_loader.sv
// Serial configuration loader for a bank of ACT C2 cells: shifts a parity-protected
// frame into a shadow register and commits it to the cell data inputs in one edge.
//
// state  | meaning
// IDLE   | waiting for start; serial port closed
// LOAD   | shifting payload bits into the shadow register
// PARITY | waiting for the even-parity bit that closes the frame
module act_c2_cfg_loader #(
  parameter int CELLS = 4,
  parameter int BITS  = 1,
  localparam int PAYLOAD = CELLS * 4 * BITS,
  localparam int CW      = $clog2(PAYLOAD + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic               sin,
  input  logic               sin_valid,
  output logic               sin_ready,
  output logic [PAYLOAD-1:0] cfg,
  output logic               cfg_valid,
  output logic               busy,
  output logic               done,
  output logic               err
);

  typedef enum logic [1:0] {IDLE, LOAD, PARITY} state_t;

  localparam logic [CW-1:0] LAST = CW'(PAYLOAD - 1);

  state_t             state, state_nxt;
  logic [PAYLOAD-1:0] shadow;
  logic [CW-1:0]      count;
  logic               parity;
  logic               accept;
  logic               commit;
  logic               fail;

  always_comb begin
    state_nxt = state;
    accept    = sin_valid && sin_ready;
    commit    = 1'b0;
    fail      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = LOAD;
      end
      LOAD: begin
        if (abort)                          state_nxt = IDLE;
        else if (accept && (count == LAST)) state_nxt = PARITY;
      end
      PARITY: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (accept) begin
          state_nxt = IDLE;
          if (parity ^ sin) fail   = 1'b1;
          else              commit = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shadow    <= '0;
      count     <= '0;
      parity    <= 1'b0;
      cfg       <= '0;
      cfg_valid <= 1'b0;
      sin_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      // Ready/busy track the next state so they are true flops yet line up with it.
      sin_ready <= (state_nxt != IDLE);
      busy      <= (state_nxt != IDLE);
      done      <= commit;
      err       <= fail;
      if (state == IDLE && start) begin
        shadow <= '0;
        count  <= '0;
        parity <= 1'b0;
      end else if (state == LOAD && accept && !abort) begin
        shadow <= {shadow[PAYLOAD-2:0], sin};
        parity <= parity ^ sin;
        count  <= count + CW'(1);
      end
      if (commit) begin
        cfg       <= shadow;
        cfg_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_act_c2_cfg_loader.sv
// Directed bench for act_c2_cfg_loader: an 8-bit-payload and a 32-bit-payload instance.
module tb_act_c2_cfg_loader;

  logic        clk;
  logic        rst_n;
  logic        start8, start32;
  logic        abort;
  logic        sin;
  logic        sin_valid;
  logic        rdy8, rdy32;
  logic [7:0]  cfg8;
  logic [31:0] cfg32;
  logic        cv8, cv32, busy8, busy32, done8, done32, err8, err32;

  int total = 0;
  int bad   = 0;
  bit spurious;

  act_c2_cfg_loader #(.CELLS(2), .BITS(1)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .abort(abort), .sin(sin),
    .sin_valid(sin_valid), .sin_ready(rdy8), .cfg(cfg8), .cfg_valid(cv8),
    .busy(busy8), .done(done8), .err(err8)
  );

  act_c2_cfg_loader #(.CELLS(4), .BITS(2)) u32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .abort(abort), .sin(sin),
    .sin_valid(sin_valid), .sin_ready(rdy32), .cfg(cfg32), .cfg_valid(cv32),
    .busy(busy32), .done(done32), .err(err32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Sends a frame MSB-first; optional 3-cycle gaps after bit counts ga/gb,
  // an extra start pulse on bit index xs, and abort raised with the parity bit.
  task automatic frame(input bit wide, input logic [31:0] data, input int n,
                       input logic par, input int ga, input int gb,
                       input int xs, input bit abort_par);
    spurious = 1'b0;
    if (wide) start32 = 1'b1; else start8 = 1'b1;
    tick();
    start8 = 1'b0; start32 = 1'b0;
    for (int i = 0; i < n; i++) begin
      sin = data[n-1-i];
      sin_valid = 1'b1;
      if (i == xs) begin
        if (wide) start32 = 1'b1; else start8 = 1'b1;
      end
      tick();
      start8 = 1'b0; start32 = 1'b0;
      if (done8 || err8 || done32 || err32) spurious = 1'b1;
      if (i + 1 == ga || i + 1 == gb) begin
        sin_valid = 1'b0;
        sin = 1'b0;
        for (int g = 0; g < 3; g++) begin
          tick();
          chk("gap_ready", {31'd0, rdy8}, 32'd1);
          chk("gap_busy", {31'd0, busy8}, 32'd1);
        end
      end
    end
    sin = par;
    sin_valid = 1'b1;
    abort = abort_par;
    tick();
    abort = 1'b0;
    sin_valid = 1'b0;
    sin = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1; start8 = 1'b0; start32 = 1'b0; abort = 1'b0; sin = 1'b0; sin_valid = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_cfg", {24'd0, cfg8}, 32'h0);
    chk("rst_flags", {27'd0, cv8, busy8, done8, err8, rdy8}, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // abort in IDLE is harmless
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("idle_abort_busy", {31'd0, busy8}, 32'd0);

    // good frame 0xA6
    frame(1'b0, 32'hA6, 8, 1'b0, 0, 0, -1, 1'b0);
    chk("a6_cfg", {24'd0, cfg8}, 32'hA6);
    chk("a6_done", {31'd0, done8}, 32'd1);
    chk("a6_err", {31'd0, err8}, 32'd0);
    chk("a6_busy", {31'd0, busy8}, 32'd0);
    chk("a6_ready", {31'd0, rdy8}, 32'd0);
    chk("a6_valid", {31'd0, cv8}, 32'd1);
    chk("a6_spurious", {31'd0, spurious}, 32'd0);
    tick();
    chk("a6_done_pulse", {31'd0, done8}, 32'd0);

    // same payload, wrong parity
    frame(1'b0, 32'hA6, 8, 1'b1, 0, 0, -1, 1'b0);
    chk("par_err", {31'd0, err8}, 32'd1);
    chk("par_done", {31'd0, done8}, 32'd0);
    chk("par_cfg", {24'd0, cfg8}, 32'hA6);
    chk("par_valid", {31'd0, cv8}, 32'd1);
    tick();
    chk("par_err_pulse", {31'd0, err8}, 32'd0);

    // 0xFF with idle gaps after bits 2 and 5
    frame(1'b0, 32'hFF, 8, 1'b0, 2, 5, -1, 1'b0);
    chk("gap_cfg", {24'd0, cfg8}, 32'hFF);
    chk("gap_done", {31'd0, done8}, 32'd1);
    tick();

    // commit A6, then abort a frame after 4 bits
    frame(1'b0, 32'hA6, 8, 1'b0, 0, 0, -1, 1'b0);
    chk("pre_abort_cfg", {24'd0, cfg8}, 32'hA6);
    tick();
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sin = 1'b1; sin_valid = 1'b1;
      tick();
    end
    sin_valid = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", {31'd0, busy8}, 32'd0);
    chk("abort_ready", {31'd0, rdy8}, 32'd0);
    chk("abort_pulses", {30'd0, done8, err8}, 32'd0);
    chk("abort_cfg", {24'd0, cfg8}, 32'hA6);
    tick();
    frame(1'b0, 32'h3C, 8, 1'b0, 0, 0, -1, 1'b0);
    chk("3c_cfg", {24'd0, cfg8}, 32'h3C);
    chk("3c_done", {31'd0, done8}, 32'd1);
    tick();

    // extra start mid-frame is ignored; 0x5A commits normally
    frame(1'b0, 32'h5A, 8, 1'b0, 0, 0, 3, 1'b0);
    chk("xs_cfg", {24'd0, cfg8}, 32'h5A);
    chk("xs_done", {31'd0, done8}, 32'd1);
    // start in the done cycle opens the next frame at once
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    chk("restart_ready", {31'd0, rdy8}, 32'd1);
    chk("restart_busy", {31'd0, busy8}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      sin = (i == 0 || i == 7); sin_valid = 1'b1;
      tick();
    end
    sin = 1'b0; sin_valid = 1'b1; abort = 1'b1;
    tick();
    abort = 1'b0; sin_valid = 1'b0;
    chk("abortpar_pulses", {30'd0, done8, err8}, 32'd0);
    chk("abortpar_cfg", {24'd0, cfg8}, 32'h5A);
    chk("abortpar_busy", {31'd0, busy8}, 32'd0);
    tick();

    // reset mid-frame is asynchronous and wipes the committed cfg
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sin = 1'b1; sin_valid = 1'b1;
      tick();
    end
    rst_n = 1'b0;
    #2;
    chk("arst_cfg", {24'd0, cfg8}, 32'h0);
    chk("arst_flags", {27'd0, cv8, busy8, done8, err8, rdy8}, 32'h0);
    sin_valid = 1'b0;
    #2 rst_n = 1'b1;
    tick();

    // 32-bit payload, four cells of two-bit inputs
    frame(1'b1, 32'h0123_4567, 32, 1'b0, 0, 0, -1, 1'b0);
    chk("w_cfg", cfg32, 32'h0123_4567);
    chk("w_done", {31'd0, done32}, 32'd1);
    chk("w_c0_d00", {30'd0, cfg32[1:0]}, 32'd3);
    chk("w_c3_d11", {30'd0, cfg32[31:30]}, 32'd0);
    chk("w_valid", {31'd0, cv32}, 32'd1);
    chk("w_narrow_idle", {24'd0, cfg8}, 32'h0);
    tick();
    frame(1'b1, 32'hFFFF_0001, 32, 1'b0, 0, 0, -1, 1'b0);
    chk("w_bad_err", {31'd0, err32}, 32'd1);
    chk("w_bad_cfg", cfg32, 32'h0123_4567);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
